day1: RTL and testbench



---
 rtl/day1_pkg.sv | 11 +
 rtl/day1_mux2.sv | 18 +
 rtl/day1.sv | 40 ++++
 tb/tb_day1.sv | 126 ++++++++++++
 4 files changed

// File: rtl/day1_pkg.sv
// Shared definitions for the day1 registered 2:1 multiplexer.
package day1_pkg;

   localparam int DAY1_WIDTH_DEFAULT = 8;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_t;

endpackage

// File: rtl/day1_mux2.sv
// Purely combinational 2:1 word select; only the chosen input reaches mux_d.
module mux2
   import day1_pkg::*;
#(
   parameter int WIDTH = DAY1_WIDTH_DEFAULT
) (
   input  sel_t             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] mux_d
);

   always_comb begin
      mux_d = a;
      if (sel == SEL_B) mux_d = b;
   end

endmodule

// File: rtl/day1.sv
// Registered 2:1 multiplexer: one-cycle latency, synchronous active-low clear.
module day1
   import day1_pkg::*;
#(
   parameter int WIDTH = DAY1_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] y_o
);

   logic [WIDTH-1:0] mux_d;
   logic [WIDTH-1:0] y_p1;

   mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .sel   (sel_t'(sel_i)),
      .a     (a_i),
      .b     (b_i),
      .mux_d (mux_d)
   );

   // p0 -> p1: output register, clear has priority over data
   always_ff @(posedge clk) begin
      if (!reset_n) y_p1 <= '0;
      else          y_p1 <= mux_d;
   end

   assign y_o = y_p1;

   always @(posedge clk) begin
      if (reset_n) begin
         assert (!$isunknown(sel_i))
            else $error("day1: sel_i unknown at active clock edge");
      end
   end

endmodule

// File: tb/tb_day1.sv
// Bench for day1 at WIDTH 8, 1 and 32: directed literals plus random traffic vs a behavioural model.
module tb_day1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  a8, b8, y8;
   logic        s8;
   logic [0:0]  a1, b1, y1;
   logic        s1;
   logic [31:0] a32, b32, y32;
   logic        s32;

   int n_cmp = 0;
   int n_bad = 0;

   day1 #(.WIDTH(8)) u_d8 (
      .clk(clk), .reset_n(reset_n), .a_i(a8), .b_i(b8), .sel_i(s8), .y_o(y8)
   );
   day1 #(.WIDTH(1)) u_d1 (
      .clk(clk), .reset_n(reset_n), .a_i(a1), .b_i(b1), .sel_i(s1), .y_o(y1)
   );
   day1 #(.WIDTH(32)) u_d32 (
      .clk(clk), .reset_n(reset_n), .a_i(a32), .b_i(b32), .sel_i(s32), .y_o(y32)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, got, want);
      end
   endtask

   // Model: the output after an edge is what the spec's rules say that edge sampled.
   logic [7:0]  e8;
   logic [0:0]  e1;
   logic [31:0] e32;
   bit          armed = 1'b0;

   always @(posedge clk) begin
      if (!reset_n) begin
         e8 = '0; e1 = '0; e32 = '0;
         armed = 1'b1;
      end else begin
         e8  = s8  ? b8  : a8;
         e1  = s1  ? b1  : a1;
         e32 = s32 ? b32 : a32;
      end
      #1;
      if (armed) begin
         chk("y8_edge", {24'd0, y8}, {24'd0, e8});
         chk("y1_edge", {31'd0, y1}, {31'd0, e1});
         chk("y32_edge", y32, e32);
      end
      #3;
      if (armed) begin
         chk("y8_hold", {24'd0, y8}, {24'd0, e8});
         chk("y32_hold", y32, e32);
      end
   end

   // Narrow and wide instances see fresh random data every cycle.
   initial begin
      a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
      forever begin
         @(negedge clk);
         a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
         a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
      end
   end

   task automatic lit(input string nm, input logic [7:0] want);
      @(posedge clk);
      #2;
      chk(nm, {24'd0, y8}, {24'd0, want});
   endtask

   initial begin
      reset_n = 1'b0;
      a8 = 8'hA5; b8 = 8'h5A; s8 = 1'b1;
      lit("reset_edge1", 8'h00);
      lit("reset_edge2", 8'h00);

      @(negedge clk);
      reset_n = 1'b1; a8 = 8'h3C; b8 = 8'hC3; s8 = 1'b0;
      lit("select_a", 8'h3C);
      @(negedge clk);
      s8 = 1'b1;
      lit("select_b", 8'hC3);

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a8 = 8'hFF; b8 = 8'h00; s8 = i[0];
         lit("toggle", (i % 2 == 1) ? 8'h00 : 8'hFF);
         a8 = 8'($urandom); b8 = 8'($urandom);
      end

      @(negedge clk);
      a8 = 8'h3C; b8 = 8'hC3; s8 = 1'b1;
      lit("pre_reset", 8'hC3);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("reset_sync_hold", {24'd0, y8}, 32'h0000_00C3);
      lit("mid_reset", 8'h00);
      @(negedge clk);
      reset_n = 1'b1; s8 = 1'b0; a8 = 8'h11;
      lit("post_reset", 8'h11);

      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
         reset_n = ($urandom_range(0, 9) != 0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #6;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
